trn_ep_arb_n: RTL and testbench

//  N-channel arbiter for the shared TRN tx endpoint; successor of the fixed tx/rx/irq arbiter.

---
 rtl/trn_ep_arb_n.sv | 175 +++++++++++++++++
 tb/tb_trn_ep_arb_n.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trn_ep_arb_n.sv
// N-channel arbiter for the shared TRN tx endpoint: round-robin grant with an optional
// priority channel, grant timeout, owner-only tx mux to the core and sticky violation flags.
module trn_ep_arb_n #(
    parameter int NCH      = 4,
    parameter int DW       = 64,
    parameter int ACK_TO   = 8,
    parameter int PRIO_EN  = 1,
    parameter int PRIO_CH  = 0,
    parameter int UPSTREAM = 1,
    localparam int REMW    = DW / 8,
    localparam int OW      = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req_ep,
    input  logic [NCH-1:0]       drv_ep,
    output logic [NCH-1:0]       my_trn,
    input  logic [NCH*DW-1:0]    ch_td,
    input  logic [NCH*REMW-1:0]  ch_trem_n,
    input  logic [NCH-1:0]       ch_tsof_n,
    input  logic [NCH-1:0]       ch_teof_n,
    input  logic [NCH-1:0]       ch_tsrc_rdy_n,
    output logic [DW-1:0]        trn_td,
    output logic [REMW-1:0]      trn_trem_n,
    output logic                 trn_tsof_n,
    output logic                 trn_teof_n,
    output logic                 trn_tsrc_rdy_n,
    input  logic                 up_trn,
    output logic                 up_drvn,
    output logic                 up_reqep,
    output logic [OW-1:0]        owner,
    output logic [NCH-1:0]       err_viol,
    output logic                 err_to
);

    localparam int TW = $clog2(ACK_TO + 1);
    localparam logic [OW-1:0] PRIO_IDX = OW'(PRIO_CH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_UP = 3'd1,
        S_SELECT  = 3'd2,
        S_GRANT   = 3'd3,
        S_DRIVE   = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t          r_state;
    logic [OW-1:0]   r_rr_ptr;
    logic [TW-1:0]   r_to_cnt;

    logic            w_win_vld;
    logic [OW-1:0]   w_win_idx;
    logic [OW-1:0]   w_cand;
    logic            w_drv_own;
    logic            w_active;
    logic            w_sel_go;

    // Winner selection: priority channel first, else nearest requester after rr_ptr.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        if ((PRIO_EN != 0) && req_ep[PRIO_IDX]) begin
            w_win_vld = 1'b1;
            w_win_idx = PRIO_IDX;
        end else begin
            // Descending scan so the closest candidate is the one left standing.
            for (int k = NCH; k >= 1; k--) begin
                w_cand = OW'((int'(r_rr_ptr) + k) % NCH);
                if (req_ep[w_cand]) begin
                    w_win_vld = 1'b1;
                    w_win_idx = w_cand;
                end else begin
                    w_win_vld = w_win_vld;
                end
            end
        end
    end

    assign w_drv_own = drv_ep[owner];
    assign w_active  = ((r_state == S_GRANT) || (r_state == S_DRIVE)) && !rst;
    assign w_sel_go  = (r_state == S_SELECT) || (UPSTREAM == 0) || up_trn;
    assign up_reqep  = !rst && ((r_state == S_IDLE) || (r_state == S_WAIT_UP)) && (|req_ep);

    // Grant FSM with registered grant, upstream hold, owner and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= OW'(NCH - 1);
            r_to_cnt <= '0;
            my_trn   <= '0;
            up_drvn  <= 1'b0;
            owner    <= '0;
            err_viol <= '0;
            err_to   <= 1'b0;
        end else begin
            err_viol <= err_viol | (drv_ep & ~my_trn);
            case (r_state)
                S_IDLE: begin
                    if (|req_ep) begin
                        r_state <= (UPSTREAM != 0) ? S_WAIT_UP : S_SELECT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_UP, S_SELECT: begin
                    if (w_sel_go) begin
                        if (w_win_vld) begin
                            owner    <= w_win_idx;
                            my_trn   <= {{(NCH-1){1'b0}}, 1'b1} << w_win_idx;
                            up_drvn  <= 1'b1;
                            r_to_cnt <= '0;
                            r_state  <= S_GRANT;
                        end else begin
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_GRANT: begin
                    // A drive seen on the timeout cycle still wins.
                    if (w_drv_own) begin
                        r_state <= S_DRIVE;
                    end else if (r_to_cnt == TW'(ACK_TO - 1)) begin
                        r_state <= S_RELEASE;
                        my_trn  <= '0;
                        up_drvn <= 1'b0;
                        err_to  <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                S_DRIVE: begin
                    if (!w_drv_own) begin
                        r_state <= S_RELEASE;
                        my_trn  <= '0;
                        up_drvn <= 1'b0;
                    end else begin
                        r_state <= S_DRIVE;
                    end
                end
                S_RELEASE: begin
                    r_rr_ptr <= owner;
                    r_to_cnt <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    my_trn  <= '0;
                    up_drvn <= 1'b0;
                end
            endcase
        end
    end

    // Owner-only tx mux; idle values whenever no grant is live.
    always_comb begin
        if (w_active) begin
            trn_td         = ch_td[int'(owner) * DW +: DW];
            trn_trem_n     = ch_trem_n[int'(owner) * REMW +: REMW];
            trn_tsof_n     = ch_tsof_n[owner];
            trn_teof_n     = ch_teof_n[owner];
            trn_tsrc_rdy_n = ch_tsrc_rdy_n[owner];
        end else begin
            trn_td         = '0;
            trn_trem_n     = '1;
            trn_tsof_n     = 1'b1;
            trn_teof_n     = 1'b1;
            trn_tsrc_rdy_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_trn_ep_arb_n.sv
// Bench for trn_ep_arb_n: directed grant/timeout/upstream/mux/reset steps on a plain
// round-robin instance and a priority instance, then randomized grants against a winner model.
module tb_trn_ep_arb_n;

    localparam int NCH  = 4;
    localparam int DW   = 64;
    localparam int REMW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            sel;
    logic            up_trn;
    logic [3:0]      req;
    logic [3:0]      drv;
    logic [63:0]     td   [NCH];
    logic [7:0]      trem [NCH];
    logic [3:0]      sof_n, eof_n, rdy_n;
    logic [NCH*DW-1:0]   ch_td;
    logic [NCH*REMW-1:0] ch_trem_n;

    logic [3:0]  req_a, drv_a, req_b, drv_b;
    logic [3:0]  my_trn_a, my_trn_b, err_viol_a, err_viol_b;
    logic [63:0] trn_td_a, trn_td_b;
    logic [7:0]  trem_a, trem_b;
    logic        sof_a, sof_b, eof_a, eof_b, rdy_a, rdy_b;
    logic        up_drvn_a, up_drvn_b, up_reqep_a, up_reqep_b, err_to_a, err_to_b;
    logic [1:0]  owner_a, owner_b;

    int n_chk = 0;
    int n_fail = 0;

    always_comb begin
        ch_td     = '0;
        ch_trem_n = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_td[i*DW +: DW]       = td[i];
            ch_trem_n[i*REMW +: REMW] = trem[i];
        end
    end

    assign req_a = sel ? 4'b0000 : req;
    assign drv_a = sel ? 4'b0000 : drv;
    assign req_b = sel ? req : 4'b0000;
    assign drv_b = sel ? drv : 4'b0000;

    wire [3:0]  my_trn_s   = sel ? my_trn_b   : my_trn_a;
    wire [63:0] trn_td_s   = sel ? trn_td_b   : trn_td_a;
    wire [7:0]  trem_s     = sel ? trem_b     : trem_a;
    wire        sof_s      = sel ? sof_b      : sof_a;
    wire        eof_s      = sel ? eof_b      : eof_a;
    wire        rdy_s      = sel ? rdy_b      : rdy_a;
    wire        up_drvn_s  = sel ? up_drvn_b  : up_drvn_a;
    wire        up_reqep_s = sel ? up_reqep_b : up_reqep_a;
    wire        err_to_s   = sel ? err_to_b   : err_to_a;
    wire [1:0]  owner_s    = sel ? owner_b    : owner_a;
    wire [3:0]  err_viol_s = sel ? err_viol_b : err_viol_a;

    trn_ep_arb_n #(.NCH(4), .DW(64), .ACK_TO(8), .PRIO_EN(0), .PRIO_CH(0), .UPSTREAM(1)) u_rr (
        .clk(clk), .rst(rst), .req_ep(req_a), .drv_ep(drv_a), .my_trn(my_trn_a),
        .ch_td(ch_td), .ch_trem_n(ch_trem_n), .ch_tsof_n(sof_n), .ch_teof_n(eof_n),
        .ch_tsrc_rdy_n(rdy_n), .trn_td(trn_td_a), .trn_trem_n(trem_a), .trn_tsof_n(sof_a),
        .trn_teof_n(eof_a), .trn_tsrc_rdy_n(rdy_a), .up_trn(up_trn), .up_drvn(up_drvn_a),
        .up_reqep(up_reqep_a), .owner(owner_a), .err_viol(err_viol_a), .err_to(err_to_a)
    );

    trn_ep_arb_n #(.NCH(4), .DW(64), .ACK_TO(8), .PRIO_EN(1), .PRIO_CH(3), .UPSTREAM(1)) u_pr (
        .clk(clk), .rst(rst), .req_ep(req_b), .drv_ep(drv_b), .my_trn(my_trn_b),
        .ch_td(ch_td), .ch_trem_n(ch_trem_n), .ch_tsof_n(sof_n), .ch_teof_n(eof_n),
        .ch_tsrc_rdy_n(rdy_n), .trn_td(trn_td_b), .trn_trem_n(trem_b), .trn_tsof_n(sof_b),
        .trn_teof_n(eof_b), .trn_tsrc_rdy_n(rdy_b), .up_trn(up_trn), .up_drvn(up_drvn_b),
        .up_reqep(up_reqep_b), .owner(owner_b), .err_viol(err_viol_b), .err_to(err_to_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NCH; i++) begin
            td[i]   = {$urandom, $urandom};
            trem[i] = 8'($urandom);
        end
        sof_n = 4'($urandom);
        eof_n = 4'($urandom);
        rdy_n = 4'($urandom);
    endtask

    task automatic check_mux(input logic [1:0] e);
        chk("mux_td",   trn_td_s, td[e]);
        chk("mux_trem", 64'(trem_s), 64'(trem[e]));
        chk("mux_sof",  64'(sof_s), 64'(sof_n[e]));
        chk("mux_eof",  64'(eof_s), 64'(eof_n[e]));
        chk("mux_rdy",  64'(rdy_s), 64'(rdy_n[e]));
    endtask

    task automatic check_idle();
        chk("idle_td",   trn_td_s, 64'd0);
        chk("idle_trem", 64'(trem_s), 64'hFF);
        chk("idle_sof",  64'(sof_s), 64'd1);
        chk("idle_eof",  64'(eof_s), 64'd1);
        chk("idle_rdy",  64'(rdy_s), 64'd1);
    endtask

    task automatic wait_grant();
        int cyc;
        cyc = 0;
        while ((my_trn_s == 4'b0000) && (cyc < 12)) begin
            tick();
            cyc++;
        end
    endtask

    // Reference winner: priority channel if enabled and requesting, else first after last owner.
    function automatic int pick(input logic [3:0] r, input int last, input bit prio);
        int j;
        if (prio && r[3]) return 3;
        for (int k = 1; k <= 4; k++) begin
            j = (last + k) % 4;
            if (r[j[1:0]]) return j;
        end
        return 0;
    endfunction

    // One grant: request, expect winner, either drive len beats or let the grant time out.
    task automatic do_txn(input logic [3:0] r, input logic [3:0] r_after, input int exp,
                          input int len, input bit to_case);
        logic [1:0] e;
        int cnt;
        e = exp[1:0];
        req = r;
        wait_grant();
        chk("grant", 64'(my_trn_s), 64'(4'b0001 << e));
        chk("owner", 64'(owner_s), 64'(e));
        chk("up_drvn_on", 64'(up_drvn_s), 64'd1);
        if (!to_case) begin
            drv[e] = 1'b1;
            req = r_after;
            rand_data();
            #1;
            check_mux(e);
            repeat (len) begin
                tick();
                rand_data();
                #1;
                check_mux(e);
            end
            drv[e] = 1'b0;
            tick();
        end else begin
            cnt = 0;
            while (my_trn_s[e] && (cnt < 20)) begin
                cnt++;
                tick();
            end
            chk("to_len", 64'(cnt), 64'd8);
            chk("err_to", 64'(err_to_s), 64'd1);
        end
        chk("release_grant", 64'(my_trn_s), 64'd0);
        chk("release_up_drvn", 64'(up_drvn_s), 64'd0);
        check_idle();
    endtask

    initial begin
        int last;
        int exp;
        logic [3:0] r;
        rst = 1'b1; sel = 1'b0; up_trn = 1'b1; req = '0; drv = '0;
        rand_data();
        tick(); tick();
        // Reset state of both instances.
        chk("rst_my_trn", 64'({my_trn_a, my_trn_b}), 64'd0);
        chk("rst_up_drvn", 64'({up_drvn_a, up_drvn_b}), 64'd0);
        chk("rst_up_reqep", 64'({up_reqep_a, up_reqep_b}), 64'd0);
        chk("rst_owner", 64'({owner_a, owner_b}), 64'd0);
        chk("rst_err", 64'({err_viol_a, err_viol_b, err_to_a, err_to_b}), 64'd0);
        check_idle();
        rst = 1'b0;

        // Round-robin with all channels requesting: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) do_txn(4'b1111, 4'b1111, k % 4, 3, 1'b0);

        // Timeout on ch2, then ch3 served.
        chk("err_to_clear", 64'(err_to_s), 64'd0);
        do_txn(4'b1100, 4'b1100, 2, 0, 1'b1);
        do_txn(4'b1100, 4'b1100, 3, 2, 1'b0);

        // Upstream holding off the grant.
        up_trn = 1'b0;
        req = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("wait_up_reqep", 64'(up_reqep_s), 64'd1);
            chk("wait_my_trn", 64'(my_trn_s), 64'd0);
        end
        up_trn = 1'b1;
        tick();
        chk("up_grant", 64'(my_trn_s), 64'b0010);
        drv[1] = 1'b1; tick(); drv[1] = 1'b0; tick();
        chk("up_release", 64'(my_trn_s), 64'd0);

        // Mux isolation and violation flag.
        req = 4'b0001;
        wait_grant();
        chk("viol_grant", 64'(my_trn_s), 64'b0001);
        drv[0] = 1'b1; td[0] = 64'hA5A5_A5A5_A5A5_A5A5; rdy_n[0] = 1'b0;
        drv[1] = 1'b1; td[1] = 64'hFFFF_FFFF_FFFF_FFFF; rdy_n[1] = 1'b0;
        #1;
        chk("viol_td", trn_td_s, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("viol_rdy", 64'(rdy_s), 64'd0);
        tick();
        drv[1] = 1'b0;
        chk("err_viol", 64'(err_viol_s), 64'b0010);
        chk("viol_td2", trn_td_s, 64'hA5A5_A5A5_A5A5_A5A5);
        drv[0] = 1'b0;
        tick();
        chk("viol_release", 64'(my_trn_s), 64'd0);

        // Priority channel wins after the current owner releases.
        sel = 1'b1;
        do_txn(4'b0010, 4'b1110, 1, 3, 1'b0);
        do_txn(4'b1100, 4'b1100, 3, 2, 1'b0);
        do_txn(4'b0100, 4'b0100, 2, 2, 1'b0);

        // Reset during DRIVE.
        sel = 1'b0;
        req = 4'b1000;
        wait_grant();
        chk("pre_rst_grant", 64'(my_trn_s), 64'b1000);
        drv[3] = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_rdy_now", 64'(rdy_s), 64'd1);
        chk("rst_td_now", trn_td_s, 64'd0);
        chk("rst_my_trn_hold", 64'(my_trn_s), 64'b1000);
        tick();
        chk("rst_my_trn_drop", 64'(my_trn_s), 64'd0);
        chk("rst_up_drvn_drop", 64'(up_drvn_s), 64'd0);
        chk("rst_err_clear", 64'({err_viol_s, err_to_s}), 64'd0);
        chk("rst_owner_clear", 64'(owner_s), 64'd0);
        drv = '0;
        rst = 1'b0;
        do_txn(4'b1111, 4'b1111, 0, 2, 1'b0);

        // Randomized grants on the priority instance against the winner model.
        sel = 1'b1;
        last = 3;
        for (int t = 0; t < 40; t++) begin
            r = 4'($urandom_range(1, 15));
            exp = pick(r, last, 1'b1);
            do_txn(r, r, exp, $urandom_range(1, 3), ($urandom_range(0, 5) == 0));
            last = exp;
        end
        chk("rand_no_viol", 64'(err_viol_s), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
